dcache_port_arbiter: RTL and testbench
======================================

// Module: dcache_port_arbiter
// PURPOSE
//   Shares the single D-cache request port between the LSU store/load buffer (port 0) and an auxiliary
//   requester (port 1: page-table walker / debug memory access). Holds one transaction outstanding,
//   tracks its owner and routes the D-cache response back to that owner only. Sits between
//   stage04_memory and the D-cache.
// PARAMETERS
//   STARVE_LIMIT  4  consecutive LSU grants while AUX waits before AUX is forced to win (>=1)
// PORTS
//   clk_i          in   1             clock
//   rst_ni         in   1             asynchronous active-low reset
//   flush_i        in   1             pipeline flush / fence.i; drops delivery of in-flight response
//   lsu_req_i      in   dcache_req_t  LSU request; valid held until lsu_gnt_o
//   lsu_gnt_o      out  1             1-cycle pulse: LSU request issued to D-cache this cycle
//   lsu_res_o      out  dcache_res_t  response to LSU (valid only for LSU-owned txn)
//   aux_req_i      in   dcache_req_t  AUX request; valid held until aux_gnt_o
//   aux_gnt_o      out  1             1-cycle pulse: AUX request issued this cycle
//   aux_res_o      out  dcache_res_t  response to AUX
//   dcache_req_o   out  dcache_req_t  request to D-cache
//   dcache_res_i   in   dcache_res_t  response from D-cache
//   busy_o         out  1             transaction outstanding (state BUSY)
// BEHAVIOUR
//   - Reset: state IDLE, owner=LSU, starve_cnt=0, rr_last=AUX; all outputs 0 (struct fields all 0).
//   - FSM IDLE: if any req valid, select winner, drive dcache_req_o = winner req (combinational,
//     same cycle), dcache_req_o.ready=1, pulse winner gnt, latch owner, -> BUSY. No valid: req.valid=0.
//   - FSM BUSY: dcache_req_o.valid=0, no grants. On dcache_res_i.valid: copy to owner res port
//     (other port res.valid=0), -> IDLE. New issue earliest the cycle after the response (1 bubble).
//   - Response data/valid passed through combinationally; zero added latency on response path.
//   - Selection (fixed priority): LSU wins unless starve_cnt==STARVE_LIMIT and AUX valid.
//     starve_cnt: +1 on LSU grant while AUX valid; cleared on AUX grant or AUX valid low;
//     saturates at STARVE_LIMIT. Width $clog2(STARVE_LIMIT+1).
//   - Both valid, counter below limit: LSU granted, AUX stays pending (must hold valid).
//   - flush_i in IDLE: no effect on selection that cycle except starve_cnt cleared.
//   - flush_i in BUSY: set drop flag; still wait for dcache_res_i.valid (cache not abortable), then
//     suppress res.valid to owner, -> IDLE, clear drop. flush_i on the response cycle also drops.
//   - dcache_res_i.valid in IDLE: ignored (protocol violation, asserted in sim).
//   - Req fields sampled only on grant cycle; arbiter does not buffer requests.
//   - Reset mid-BUSY: asynchronous return to IDLE; late response afterwards ignored as above.
// CONFIGURATION
//   DCACHE_ARB_RR_EN defined: starvation counter removed; round-robin — when both valid, grant the
//     port not granted last (rr_last updated on each grant); single valid always wins.
//   Undefined: fixed LSU priority with STARVE_LIMIT escape as above. Port list identical both ways.
// TESTING
//   - Reset, LSU load addr 0x100 WORD, res data 0xDEADBEEF 2 cycles later -> lsu_gnt_o pulse cycle 0,
//     busy_o=1 cycles 1-2, lsu_res_o.valid/data=0xDEADBEEF, aux_res_o.valid=0.
//   - LSU and AUX held valid continuously, 1-cycle cache latency, STARVE_LIMIT=4 -> grants L,L,L,L,A
//     repeating; with DCACHE_ARB_RR_EN -> L,A,L,A (first grant AUX? no: rr_last=AUX -> LSU first).
//   - AUX store 0x2000 BYTE issued, flush_i during BUSY, response arrives -> aux_res_o.valid stays 0,
//     busy_o drops after response, next LSU req granted the following cycle.
//   - Response and new LSU valid same cycle -> response routed, no grant that cycle, grant next cycle.
//   - rst_ni asserted while BUSY -> all outputs 0 immediately; stray dcache_res_i.valid afterward
//     produces no lsu/aux res.valid.
//   - AUX valid alone while starve_cnt at limit drops -> counter clears to 0, AUX granted at once.

Source files
------------

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the single D-cache request port between the LSU
// (port 0) and an auxiliary requester (port 1, PTW / debug memory access).
// Keeps one transaction outstanding and routes the response back to its owner.
// Optional build macro: DCACHE_ARB_RR_EN selects round-robin arbitration in
// place of fixed LSU priority with a starvation escape. Port list is the same
// in both builds.

package dcache_arb_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef struct packed {
      logic        valid;
      logic        ready;
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dcache_req_t;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] rdata;
   } dcache_res_t;

endpackage

module dcache_port_arbiter
   import dcache_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  dcache_req_t lsu_req_i,
   output logic        lsu_gnt_o,
   output dcache_res_t lsu_res_o,
   input  dcache_req_t aux_req_i,
   output logic        aux_gnt_o,
   output dcache_res_t aux_res_o,
   output dcache_req_t dcache_req_o,
   input  dcache_res_t dcache_res_i,
   output logic        busy_o
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam logic OWN_LSU = 1'b0;
   localparam logic OWN_AUX = 1'b1;

   logic [0:0] state;
   logic       owner;
   logic       drop;
   logic       issue;
   logic       aux_win;
   logic       deliver;

`ifdef DCACHE_ARB_RR_EN
   logic rr_last;
`else
   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
   logic [CW-1:0] starve_cnt;
`endif

   // Winner selection; issue is gated by reset so nothing is granted while the block is held in reset
   always_comb begin
      issue = (state == S_IDLE) && rst_ni;
`ifdef DCACHE_ARB_RR_EN
      aux_win = aux_req_i.valid && (!lsu_req_i.valid || (rr_last == OWN_LSU));
`else
      aux_win = aux_req_i.valid && (!lsu_req_i.valid || (starve_cnt == CW'(STARVE_LIMIT)));
`endif
      lsu_gnt_o = issue && lsu_req_i.valid && !aux_win;
      aux_gnt_o = issue && aux_win;
   end

   // Request mux to the cache: the winner's request goes out in the same cycle it is granted
   always_comb begin
      dcache_req_o = '0;
      if (lsu_gnt_o) begin
         dcache_req_o       = lsu_req_i;
         dcache_req_o.valid = 1'b1;
         dcache_req_o.ready = 1'b1;
      end else if (aux_gnt_o) begin
         dcache_req_o       = aux_req_i;
         dcache_req_o.valid = 1'b1;
         dcache_req_o.ready = 1'b1;
      end
   end

   // Response routing: pass-through to the owner only, suppressed if a flush hit this transaction
   always_comb begin
      deliver   = (state == S_BUSY) && dcache_res_i.valid && !drop && !flush_i;
      lsu_res_o = '0;
      aux_res_o = '0;
      if (deliver && (owner == OWN_LSU)) lsu_res_o = dcache_res_i;
      if (deliver && (owner == OWN_AUX)) aux_res_o = dcache_res_i;
      busy_o    = (state == S_BUSY);
   end

   // Transaction FSM: one request outstanding; a flush while busy only marks the response for dropping
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= S_IDLE;
         owner <= OWN_LSU;
         drop  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (lsu_gnt_o || aux_gnt_o) begin
                  state <= S_BUSY;
                  owner <= aux_gnt_o ? OWN_AUX : OWN_LSU;
                  drop  <= 1'b0;
               end
            end
            default: begin
               if (dcache_res_i.valid) begin
                  state <= S_IDLE;
                  drop  <= 1'b0;
               end else if (flush_i) begin
                  drop  <= 1'b1;
               end
            end
         endcase
      end
   end

`ifdef DCACHE_ARB_RR_EN
   // Remember which port was granted last so a tie goes to the other one
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_last <= OWN_AUX;
      end else if (lsu_gnt_o) begin
         rr_last <= OWN_LSU;
      end else if (aux_gnt_o) begin
         rr_last <= OWN_AUX;
      end
   end
`else
   // Count LSU wins while AUX is waiting; at the limit AUX is forced through
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starve_cnt <= '0;
      end else if (flush_i && (state == S_IDLE)) begin
         starve_cnt <= '0;
      end else if (!aux_req_i.valid || aux_gnt_o) begin
         starve_cnt <= '0;
      end else if (lsu_gnt_o && (starve_cnt != CW'(STARVE_LIMIT))) begin
         starve_cnt <= starve_cnt + CW'(1);
      end
   end
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Testbench for dcache_port_arbiter: directed scenarios followed by a random
// phase, all compared against a transaction-level model of the arbiter.
module tb_dcache_port_arbiter;
   import dcache_arb_pkg::*;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   dcache_req_t lsu_req, aux_req, dreq;
   dcache_res_t lsu_res, aux_res, dres;
   logic        lsu_gnt, aux_gnt, busy;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   bit m_busy, m_owner_aux, m_drop, m_last_aux;
   int m_starve;
   bit e_lsu_gnt, e_aux_gnt;

   // pending requests held by the requesters until granted
   dcache_req_t lsu_pend, aux_pend;
   bit          grant_log[$];

   dcache_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .lsu_req_i(lsu_req), .lsu_gnt_o(lsu_gnt), .lsu_res_o(lsu_res),
      .aux_req_i(aux_req), .aux_gnt_o(aux_gnt), .aux_res_o(aux_res),
      .dcache_req_o(dreq), .dcache_res_i(dres), .busy_o(busy)
   );

   always #5 clk = ~clk;

   function automatic dcache_req_t rand_req();
      dcache_req_t r;
      r.valid = 1'b0;
      r.ready = 1'($urandom);
      r.we    = 1'($urandom);
      r.size  = 2'($urandom_range(0, 2));
      r.addr  = $urandom;
      r.wdata = $urandom;
      return r;
   endfunction

   task automatic check_output(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_owner_aux = 0; m_drop = 0; m_last_aux = 1; m_starve = 0;
   endtask

   // One clock cycle: drive inputs, check every output against the model, advance the model
   task automatic apply_stimulus(input bit lv, input bit av, input bit rv, input bit fl,
                                 input logic [31:0] rdata);
      bit          aux_win, deliver;
      dcache_req_t e_req;
      dcache_res_t e_lres, e_ares;
      lsu_req       = lsu_pend; lsu_req.valid = lv;
      aux_req       = aux_pend; aux_req.valid = av;
      dres.valid    = rv; dres.err = 1'($urandom); dres.rdata = rdata;
      flush         = fl;
      #4;
`ifdef DCACHE_ARB_RR_EN
      aux_win = av && (!lv || !m_last_aux);
`else
      aux_win = av && (!lv || (m_starve == LIMIT));
`endif
      e_lsu_gnt = !m_busy && lv && !aux_win;
      e_aux_gnt = !m_busy && aux_win;
      e_req = '0;
      if (e_lsu_gnt) e_req = lsu_pend;
      if (e_aux_gnt) e_req = aux_pend;
      if (e_lsu_gnt || e_aux_gnt) begin e_req.valid = 1'b1; e_req.ready = 1'b1; end
      deliver = m_busy && rv && !m_drop && !fl;
      e_lres = (deliver && !m_owner_aux) ? dres : '0;
      e_ares = (deliver &&  m_owner_aux) ? dres : '0;
      check_output("lsu_gnt", 80'(lsu_gnt), 80'(e_lsu_gnt));
      check_output("aux_gnt", 80'(aux_gnt), 80'(e_aux_gnt));
      check_output("dcache_req", 80'(dreq), 80'(e_req));
      check_output("lsu_res", 80'(lsu_res), 80'(e_lres));
      check_output("aux_res", 80'(aux_res), 80'(e_ares));
      check_output("busy", 80'(busy), 80'(m_busy));
      if (lsu_gnt) grant_log.push_back(1'b0);
      if (aux_gnt) grant_log.push_back(1'b1);
      // advance model
      if (fl && !m_busy)             m_starve = 0;
      else if (!av || e_aux_gnt)     m_starve = 0;
      else if (e_lsu_gnt)            m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      if (e_lsu_gnt) m_last_aux = 0;
      if (e_aux_gnt) m_last_aux = 1;
      if (!m_busy) begin
         if (e_lsu_gnt || e_aux_gnt) begin m_busy = 1; m_owner_aux = e_aux_gnt; m_drop = 0; end
      end else if (rv) begin
         m_busy = 0; m_drop = 0;
      end else if (fl) begin
         m_drop = 1;
      end
      if (e_lsu_gnt) lsu_pend = rand_req();
      if (e_aux_gnt) aux_pend = rand_req();
      @(posedge clk); #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_lsu_gnt"}, 80'(lsu_gnt), 80'(0));
      check_output({tag, "_aux_gnt"}, 80'(aux_gnt), 80'(0));
      check_output({tag, "_dreq"}, 80'(dreq), 80'(0));
      check_output({tag, "_lsu_res"}, 80'(lsu_res), 80'(0));
      check_output({tag, "_aux_res"}, 80'(aux_res), 80'(0));
      check_output({tag, "_busy"}, 80'(busy), 80'(0));
   endtask

   initial begin
      bit lsu_act, aux_act, rv;
      rst_n = 1'b0; flush = 1'b0;
      lsu_req = '0; aux_req = '0; dres = '0;
      lsu_pend = rand_req(); aux_pend = rand_req();
      model_reset();
      #2;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // LSU word load at 0x100, response two cycles after the grant
      lsu_pend = '0; lsu_pend.size = SIZE_WORD; lsu_pend.addr = 32'h100;
      apply_stimulus(1, 0, 0, 0, 32'h0);
      apply_stimulus(0, 0, 0, 0, 32'h0);
      apply_stimulus(0, 0, 1, 0, 32'hDEADBEEF);
      apply_stimulus(0, 0, 0, 0, 32'h0);

      // both requesters held valid with one-cycle cache latency
      grant_log.delete();
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1, 1, 0, 0, $urandom);
         apply_stimulus(1, 1, 1, 0, $urandom);
      end
      for (int i = 0; i < 10; i++) begin
         bit exp_aux;
`ifdef DCACHE_ARB_RR_EN
         exp_aux = (i % 2) == 1;
`else
         exp_aux = (i % 5) == 4;
`endif
         check_output("grant_order", (i < grant_log.size()) ? 80'(grant_log[i]) : 80'h2, 80'(exp_aux));
      end
      apply_stimulus(0, 0, 0, 0, 32'h0);

      // AUX byte store flushed while outstanding, then a following LSU request
      aux_pend = '0; aux_pend.we = 1'b1; aux_pend.size = SIZE_BYTE; aux_pend.addr = 32'h2000;
      apply_stimulus(0, 1, 0, 0, 32'h0);
      apply_stimulus(0, 0, 0, 1, 32'h0);
      apply_stimulus(0, 0, 0, 0, 32'h0);
      apply_stimulus(0, 0, 1, 0, 32'h12345678);
      apply_stimulus(1, 0, 0, 0, 32'h0);
      apply_stimulus(0, 0, 1, 1, 32'h55AA55AA);

      // response and a new LSU request in the same cycle
      apply_stimulus(1, 0, 0, 0, 32'h0);
      apply_stimulus(1, 0, 1, 0, 32'hCAFEF00D);
      apply_stimulus(1, 0, 0, 0, 32'h0);
      apply_stimulus(0, 0, 1, 0, 32'h0BADF00D);

      // drive the starvation count to its limit, then LSU drops and AUX wins alone
      for (int i = 0; i < LIMIT; i++) begin
         apply_stimulus(1, 1, 0, 0, $urandom);
         apply_stimulus(1, 1, 1, 0, $urandom);
      end
      apply_stimulus(0, 1, 0, 0, 32'h0);
      apply_stimulus(0, 0, 1, 0, 32'h77777777);
      apply_stimulus(1, 1, 0, 0, 32'h0);
      apply_stimulus(0, 1, 1, 0, 32'h0);

      // asynchronous reset while a transaction is outstanding
      apply_stimulus(0, 0, 0, 0, 32'h0);
      apply_stimulus(1, 0, 0, 0, 32'h0);
      lsu_req.valid = 1'b1; dres.valid = 1'b1; dres.rdata = 32'hFFFF0000;
      #1 rst_n = 1'b0;
      #1 check_all_zero("midbusy_reset");
      model_reset();
      lsu_req.valid = 1'b0; dres.valid = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      apply_stimulus(0, 0, 1, 0, 32'hABCDABCD);
      apply_stimulus(0, 0, 0, 0, 32'h0);

      // random phase: requesters hold valid until granted
      lsu_act = 0; aux_act = 0;
      for (int i = 0; i < 400; i++) begin
         if (!lsu_act) lsu_act = ($urandom % 3) == 0;
         if (!aux_act) aux_act = ($urandom % 3) == 0;
         rv = m_busy ? (($urandom % 3) == 0) : (($urandom % 12) == 0);
         apply_stimulus(lsu_act, aux_act, rv, ($urandom % 8) == 0, $urandom);
         if (e_lsu_gnt) lsu_act = 0;
         if (e_aux_gnt) aux_act = 0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
